// File: rtl/nn_err_update_if.sv
// Error-side handshake and weight-side bus between the cost stage and the weight update block.
interface nn_err_update_if #(
    parameter int unsigned NB = 16
);
    logic          sign;
    logic [NB-1:0] eps_d;
    logic          err_valid;
    logic          err_ready_c;
    logic          w_load;
    logic [NB-1:0] w_in;
    logic [NB-1:0] w;
    logic          upd;

    modport master (
        output sign, eps_d, err_valid, w_load, w_in,
        input  err_ready_c, w, upd
    );

    modport slave (
        input  sign, eps_d, err_valid, w_load, w_in,
        output err_ready_c, w, upd
    );
endinterface

// File: rtl/nn_err_update.sv
// Batch-accumulates signed cost derivatives and applies a learning-rate-scaled,
// saturating update to one unsigned weight register.
module nn_err_update #(
    parameter int unsigned NB          = 16,
    parameter int unsigned NBATCH_LOG2 = 3,
    parameter int unsigned LR_SHIFT    = 4,
    parameter int unsigned W_RST       = 32768
) (
    input  logic                clk_i,
    input  logic                init_n_i,
    nn_err_update_if.slave      bus
);
    localparam int unsigned ACC_W = NB + NBATCH_LOG2 + 1;
    localparam int unsigned SUM_W = NB + NBATCH_LOG2 + 2;
    localparam int unsigned SHIFT = NBATCH_LOG2 + LR_SHIFT;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    state_e                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [NBATCH_LOG2-1:0]   cnt_q;
    logic [NB-1:0]            w_q;
    logic                     upd_q;

    logic                     accept_c;
    logic signed [ACC_W-1:0]  eps_ext_c;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  delta_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [NB-1:0]            w_d;

    assign bus.err_ready_c = init_n_i & (state_q == ST_ACCUM) & ~bus.w_load;
    assign accept_c        = bus.err_valid & bus.err_ready_c;

    // Next accumulator value and the clamped post-update weight.
    always_comb begin
        eps_ext_c = {{(ACC_W-NB){1'b0}}, bus.eps_d};
        acc_d     = bus.sign ? (acc_q + eps_ext_c) : (acc_q - eps_ext_c);
        delta_c   = acc_q >>> SHIFT;
        sum_c     = $signed({{(SUM_W-NB){1'b0}}, w_q}) + SUM_W'(delta_c);
        w_d       = sum_c[NB-1:0];
        if (sum_c[SUM_W-1]) begin
            w_d = '0;
        end else if (|sum_c[SUM_W-2:NB]) begin
            w_d = '1;
        end
    end

    // Batch FSM: INIT beats W_LOAD, W_LOAD beats any pending update.
    always_ff @(posedge clk_i) begin
        if (!init_n_i) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= NB'(W_RST);
            upd_q   <= 1'b0;
        end else if (bus.w_load) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            w_q     <= bus.w_in;
            upd_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    upd_q <= 1'b0;
                    if (accept_c) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + NBATCH_LOG2'(1);
                        if (&cnt_q) begin
                            state_q <= ST_APPLY;
                        end
                    end
                end
                ST_APPLY: begin
                    w_q     <= w_d;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    upd_q   <= 1'b1;
                    state_q <= ST_ACCUM;
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.w   = w_q;
    assign bus.upd = upd_q;
endmodule

// File: tb/tb_nn_err_update.sv
// Self-checking bench for nn_err_update: directed batch scenarios plus random traffic
// against a sample-list reference model.
module tb_nn_err_update;
    localparam int unsigned NB    = 8;
    localparam int unsigned BATCH = 4;
    localparam int unsigned DIV   = 8;
    localparam int          W_RST = 128;
    localparam int          W_MAX = 255;

    logic clk = 1'b0;
    logic init_n;
    int   checks = 0;
    int   errors = 0;

    int   m_w;
    int   m_samples[$];
    bit   m_pend;
    bit   m_upd;

    nn_err_update_if #(.NB(NB)) bus ();

    nn_err_update #(
        .NB(NB), .NBATCH_LOG2(2), .LR_SHIFT(1), .W_RST(W_RST)
    ) dut (
        .clk_i    (clk),
        .init_n_i (init_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    // One clock cycle: drive at negedge, check ready, advance model at posedge, check W/UPD.
    task automatic step(input bit init, input bit valid, input bit sgn, input int eps,
                        input bit ld, input int win);
        bit exp_rdy;
        bit acc;
        int sum;
        int nw;
        @(negedge clk);
        init_n        = init;
        bus.err_valid = valid;
        bus.sign      = sgn;
        bus.eps_d     = NB'(eps);
        bus.w_load    = ld;
        bus.w_in      = NB'(win);
        #1;
        exp_rdy = init && !m_pend && !ld;
        check("ready", int'(bus.err_ready_c), int'(exp_rdy));
        acc = valid && exp_rdy;
        @(posedge clk);
        if (!init) begin
            m_w = W_RST; m_samples.delete(); m_pend = 0; m_upd = 0;
        end else if (ld) begin
            m_w = win; m_samples.delete(); m_pend = 0; m_upd = 0;
        end else if (m_pend) begin
            sum = 0;
            foreach (m_samples[i]) sum += m_samples[i];
            nw = m_w + floor_div(sum, DIV);
            m_w = (nw < 0) ? 0 : ((nw > W_MAX) ? W_MAX : nw);
            m_samples.delete(); m_pend = 0; m_upd = 1;
        end else begin
            m_upd = 0;
            if (acc) begin
                m_samples.push_back(sgn ? eps : -eps);
                if (m_samples.size() == BATCH) m_pend = 1;
            end
        end
        #1;
        check("w", int'(bus.w), m_w);
        check("upd", int'(bus.upd), int'(m_upd));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int v);
        step(1, 0, 0, 0, 1, v);
    endtask

    task automatic batch(input bit sgn, input int eps);
        for (int i = 0; i < 4; i++) step(1, 1, sgn, eps, 0, 0);
        step(1, 1, sgn, eps, 0, 0);
    endtask

    initial begin
        int upd_cnt;
        m_w = W_RST; m_pend = 0; m_upd = 0;
        init_n = 0; bus.err_valid = 0; bus.sign = 0; bus.eps_d = '0;
        bus.w_load = 0; bus.w_in = '0;

        // Reset and first ready cycle
        step(0, 1, 1, 5, 0, 0);
        step(0, 1, 1, 5, 1, 9);
        check("t1_w", int'(bus.w), 128);
        idle();

        // Positive batch with VALID held; the fifth offer lands in APPLY
        batch(1, 16);
        check("t2_w", int'(bus.w), 136);
        check("t2_upd", int'(bus.upd), 1);
        idle();
        check("t2_upd_gone", int'(bus.upd), 0);

        // Lower saturation, twice
        load(128);
        batch(0, 255);
        check("t3_w0", int'(bus.w), 0);
        batch(0, 255);
        check("t3_w1", int'(bus.w), 0);

        // Upper saturation
        load(250);
        batch(1, 255);
        check("t4_w", int'(bus.w), 255);
        check("t4_upd", int'(bus.upd), 1);

        // Floor of a small negative mean
        load(128);
        step(1, 1, 1, 10, 0, 0);
        step(1, 1, 0, 10, 0, 0);
        step(1, 1, 1, 3, 0, 0);
        step(1, 1, 0, 4, 0, 0);
        idle();
        check("t5_w", int'(bus.w), 127);

        // W_LOAD mid-batch aborts and rejects the concurrent sample
        load(128);
        step(1, 1, 1, 40, 0, 0);
        step(1, 1, 1, 40, 0, 0);
        step(1, 1, 1, 40, 1, 50);
        check("t6_w", int'(bus.w), 50);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8, 0, 0);
        check("t6_noupd", int'(bus.upd), 0);
        step(1, 1, 1, 8, 0, 0);
        idle();
        check("t6_w2", int'(bus.w), 54);
        // Same with an INIT pulse
        step(1, 1, 1, 40, 0, 0);
        step(1, 1, 1, 40, 0, 0);
        step(0, 1, 1, 40, 0, 0);
        check("t6_init_w", int'(bus.w), 128);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8, 0, 0);
        idle();
        check("t6_init_w2", int'(bus.w), 124);

        // VALID held 10 cycles: two full batches, two UPD pulses
        load(100);
        upd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 24, 0, 0);
            upd_cnt += int'(bus.upd);
        end
        idle();
        upd_cnt += int'(bus.upd);
        check("t7_upds", upd_cnt, 2);
        check("t7_w", int'(bus.w), 124);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 40) != 0, ($urandom % 4) != 0, 1'($urandom),
                 (($urandom % 3) == 0) ? int'($urandom_range(200, 255)) : int'($urandom % 64),
                 ($urandom % 25) == 0, int'($urandom % 256));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
